// File: rtl/bias_activation_seq_pkg.sv
// Shared float32 field layout, activation encodings and FSM state type
// for the bias + activation stage.
package bias_activation_seq_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam logic [7:0] EXP_MAX = 8'hFF;

  localparam int ACT_IDENT = 0;
  localparam int ACT_RELU  = 1;
  localparam int ACT_LEAKY = 2;

  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  function automatic logic fp_is_nan(input logic [31:0] f);
    return (f[EXP_MSB:EXP_LSB] == EXP_MAX) && (f[MAN_MSB:0] != '0);
  endfunction
endpackage

// File: rtl/bias_activation_seq_if.sv
// Start/operand/result bundle between the multiplier side and this stage.
interface bias_activation_seq_if #(parameter int VLEN = 1);
  logic                   start;
  logic [32*VLEN-1:0]     in_vec;
  logic [32*VLEN-1:0]     bias;
  logic [32*VLEN-1:0]     result;
  logic                   busy;
  logic                   done;

  modport master (output start, in_vec, bias, input result, busy, done);
  modport slave  (input start, in_vec, bias, output result, busy, done);
endinterface

// File: rtl/bias_activation_seq_lane.sv
// Combinational float32 adder (round-to-nearest-even, denormal aware) and the
// per-lane bias-add + activation wrapper built on it.
module fp32_add
  import bias_activation_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        sa, sb, sx, sy;
  logic [7:0]  ea, eb, ex, ey, ex_e, ey_e, d;
  logic [22:0] ma, mb, mx, my;
  logic [4:0]  sh, lz;
  logic [23:0] sigx, sigy, mr;
  logic [53:0] tmp;
  logic [26:0] al;
  logic [27:0] sum, nrm;
  logic [9:0]  ev, nsh;
  logic [24:0] m25;
  logic        inc;

  always_comb begin
    {sa, ea, ma} = a;
    {sb, eb, mb} = b;
    if ({eb, mb} > {ea, ma}) begin
      {sx, ex, mx} = b; {sy, ey, my} = a;
    end else begin
      {sx, ex, mx} = a; {sy, ey, my} = b;
    end
    ex_e = (ex == 8'd0) ? 8'd1 : ex;
    ey_e = (ey == 8'd0) ? 8'd1 : ey;
    sigx = {ex != 8'd0, mx};
    sigy = {ey != 8'd0, my};
    d    = ex_e - ey_e;
    sh   = (d > 8'd31) ? 5'd31 : d[4:0];
    // 3 extra LSBs (guard/round/sticky); everything shifted further folds into sticky
    tmp  = {sigy, 3'b000, 27'b0} >> sh;
    al   = tmp[53:27] | {26'b0, |tmp[26:0]};
    sum  = (sx ^ sy) ? ({1'b0, sigx, 3'b000} - {1'b0, al})
                     : ({1'b0, sigx, 3'b000} + {1'b0, al});
    ev   = {2'b0, ex_e};
    lz   = 5'd27;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    nsh  = '0;
    if (sum[27]) begin
      nrm = {1'b0, sum[27:2], sum[1] | sum[0]};
      ev  = ev + 10'd1;
    end else begin
      // left shift stops at the denormal boundary (effective exponent 1)
      nsh = ({5'b0, lz} < (ev - 10'd1)) ? {5'b0, lz} : (ev - 10'd1);
      nrm = sum << nsh;
      ev  = ev - nsh;
    end
    inc = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    m25 = {1'b0, nrm[26:3]} + {24'b0, inc};
    if (m25[24]) begin
      mr = m25[24:1];
      ev = ev + 10'd1;
    end else begin
      mr = m25[23:0];
    end
    y = {sx, (mr[23] ? ev[7:0] : 8'd0), mr[22:0]};
    if (mr[23] && ev >= 10'd255) y = {sx, EXP_MAX, 23'b0};
    if (sum == '0) y = {sa & sb, 31'b0};
    if (fp_is_nan(a))                                     y = a | 32'h0040_0000;
    else if (fp_is_nan(b))                                y = b | 32'h0040_0000;
    else if (ea == EXP_MAX && eb == EXP_MAX && sa != sb)  y = FP_QNAN;
    else if (ea == EXP_MAX)                               y = a;
    else if (eb == EXP_MAX)                               y = b;
  end
endmodule

module bias_act_lane
  import bias_activation_seq_pkg::*;
#(
  parameter int ACT         = 1,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] s;
  logic [7:0]  se;

  fp32_add u_add (.a(a), .b(b), .y(s));

  assign se = s[EXP_MSB:EXP_LSB];

  always_comb begin
    y = s;
    if (ACT == ACT_RELU) begin
      if (s[SIGN_BIT] && !fp_is_nan(s)) y = FP_POS_ZERO;
    end else if (ACT == ACT_LEAKY) begin
      // -inf and NaN share EXP_MAX and pass untouched
      if (s[SIGN_BIT] && se != EXP_MAX) begin
        if (se <= 8'(LEAKY_SHIFT)) y = FP_NEG_ZERO;
        else                       y = {1'b1, se - 8'(LEAKY_SHIFT), s[MAN_MSB:0]};
      end
    end
  end
endmodule

// File: rtl/bias_activation_seq.sv
// Bias add + activation over a captured vector, LANES elements per clock.
// Owns the FSM, group counter, operand capture and masked writeback.
module bias_activation_seq
  import bias_activation_seq_pkg::*;
#(
  parameter int VLEN        = 1,
  parameter int LANES       = 1,
  parameter int ACT         = 1,
  parameter int LEAKY_SHIFT = 3
) (
  input logic             clk,
  input logic             rst_n,
  bias_activation_seq_if.slave bus
);
  localparam int G  = (VLEN + LANES - 1) / LANES;
  localparam int CW = (G > 1) ? $clog2(G) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [32*VLEN-1:0] in_q, in_d, bias_q, bias_d, res_q, res_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [LANES-1:0][31:0] lane_a, lane_b, lane_y;
  logic [LANES-1:0]       lane_vld;
  int                     lane_idx [LANES];

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_idx[l] = int'(cnt_q) * LANES + l;
      lane_vld[l] = lane_idx[l] < VLEN;
      lane_a[l]   = '0;
      lane_b[l]   = '0;
      if (lane_vld[l]) begin
        lane_a[l] = in_q[32*lane_idx[l] +: 32];
        lane_b[l] = bias_q[32*lane_idx[l] +: 32];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bias_act_lane #(.ACT(ACT), .LEAKY_SHIFT(LEAKY_SHIFT)) u_lane (
      .a(lane_a[l]), .b(lane_b[l]), .y(lane_y[l])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    bias_d  = bias_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (bus.start) begin
      // start wins in every state, including the last RUN edge
      state_d = ST_RUN;
      cnt_d   = '0;
      in_d    = bus.in_vec;
      bias_d  = bus.bias;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      for (int l = 0; l < LANES; l++)
        if (lane_vld[l]) res_d[32*lane_idx[l] +: 32] = lane_y[l];
      if (cnt_q == CW'(G - 1)) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      bias_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      bias_q  <= bias_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.result = res_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_bias_activation_seq.sv
// Directed bench: three configurations (ReLU, leaky ReLU, identity with a
// partial last group); expected words queued at drive time, popped on done.
module tb_bias_activation_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bias_activation_seq_if #(.VLEN(2)) b0 ();
  bias_activation_seq_if #(.VLEN(2)) b1 ();
  bias_activation_seq_if #(.VLEN(5)) b2 ();

  bias_activation_seq #(.VLEN(2), .LANES(1), .ACT(1), .LEAKY_SHIFT(3)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  bias_activation_seq #(.VLEN(2), .LANES(1), .ACT(2), .LEAKY_SHIFT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  bias_activation_seq #(.VLEN(5), .LANES(2), .ACT(0), .LEAKY_SHIFT(3)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2));

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] res(input int id, input int i);
    case (id)
      0:       return b0.result[32*i +: 32];
      1:       return b1.result[32*i +: 32];
      default: return b2.result[32*i +: 32];
    endcase
  endfunction

  function automatic logic get_done(input int id);
    case (id)
      0:       return b0.done;
      1:       return b1.done;
      default: return b2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int id);
    case (id)
      0:       return b0.busy;
      1:       return b1.busy;
      default: return b2.busy;
    endcase
  endfunction

  task automatic set_ops(input int id, input logic [159:0] iv, input logic [159:0] bv);
    case (id)
      0:       begin b0.in_vec = iv[63:0]; b0.bias = bv[63:0]; end
      1:       begin b1.in_vec = iv[63:0]; b1.bias = bv[63:0]; end
      default: begin b2.in_vec = iv;       b2.bias = bv;       end
    endcase
  endtask

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       b0.start = v;
      1:       b1.start = v;
      default: b2.start = v;
    endcase
  endtask

  // called on a negedge; returns on the negedge after the start edge
  task automatic start_pulse(input int id);
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
  endtask

  task automatic push_exp(input logic [159:0] e, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(e[32*i +: 32]);
  endtask

  task automatic drive(input int id, input logic [159:0] iv, input logic [159:0] bv,
                       input logic [159:0] e, input int n);
    set_ops(id, iv, bv);
    push_exp(e, n);
    start_pulse(id);
  endtask

  // k counts clock edges after the start edge; done must rise exactly at k == g
  task automatic wait_done(input int id, input int g, input int n, input string tag);
    for (int k = 1; k <= g; k++) begin
      @(negedge clk);
      chk($sformatf("%s_done_k%0d", tag, k), 32'(get_done(id)), 32'(k == g));
      chk($sformatf("%s_busy_k%0d", tag, k), 32'(get_busy(id)), 32'(k < g));
    end
    for (int i = 0; i < n; i++) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s_sb_empty observed=empty expected=entry", tag);
      end else begin
        chk($sformatf("%s_res%0d", tag, i), res(id, i), sb_q.pop_front());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
    set_ops(0, '0, '0); set_ops(1, '0, '0); set_ops(2, '0, '0);
    #12;
    chk("rst_res0", res(0, 0), 32'h0);
    chk("rst_res1", res(0, 1), 32'h0);
    chk("rst_busy", 32'(b0.busy), 32'h0);
    chk("rst_done", 32'(b0.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ReLU: 1.0+0.5, -2.0+0.5
    drive(0, {32'hC000_0000, 32'h3F80_0000}, {32'h3F00_0000, 32'h3F00_0000},
          {32'h0000_0000, 32'h3FC0_0000}, 2);
    wait_done(0, 2, 2, "relu");

    // leaky, alpha = 1/4
    drive(1, {32'hC000_0000, 32'h3F80_0000}, {32'h3F00_0000, 32'h3F00_0000},
          {32'hBEC0_0000, 32'h3FC0_0000}, 2);
    wait_done(1, 2, 2, "leaky");
    drive(1, {32'hFF80_0000, 32'h8080_0000}, {32'h0, 32'h0},
          {32'hFF80_0000, 32'h8000_0000}, 2);
    wait_done(1, 2, 2, "leaky_edge");

    // identity, VLEN=5 LANES=2 -> 3 groups, last one half masked
    drive(2, {32'h4040_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h4000_0000, 32'h3F80_0000},
          {5{32'h3F00_0000}},
          {32'h4060_0000, 32'h3F80_0000, 32'hBF00_0000, 32'h4020_0000, 32'h3FC0_0000}, 5);
    wait_done(2, 3, 5, "ident5");

    // ReLU edge sums: NaN, -0 + -0
    drive(0, {32'h8000_0000, 32'h7FC0_0000}, {32'h8000_0000, 32'h0},
          {32'h0000_0000, 32'h7FC0_0000}, 2);
    wait_done(0, 2, 2, "relu_nan_negz");
    set_ops(0, {32'h4000_0000, 32'h4000_0000}, {32'h4000_0000, 32'h4000_0000});
    repeat (3) @(negedge clk);
    chk("nostart_res0", res(0, 0), 32'h7FC0_0000);
    chk("nostart_res1", res(0, 1), 32'h0000_0000);
    chk("nostart_done", 32'(b0.done), 32'h1);

    // +inf, 1.0+0.5 (started from DONE)
    drive(0, {32'h3F80_0000, 32'h7F80_0000}, {32'h3F00_0000, 32'h0},
          {32'h3FC0_0000, 32'h7F80_0000}, 2);
    wait_done(0, 2, 2, "relu_inf");

    // restart: second start lands on what would have been the completion edge
    set_ops(0, {32'h4000_0000, 32'h4000_0000}, {32'h0, 32'h0});
    start_pulse(0);
    @(negedge clk);
    chk("restart_pre_done", 32'(b0.done), 32'h0);
    drive(0, {32'hC000_0000, 32'h4040_0000}, {32'h3F00_0000, 32'h3F00_0000},
          {32'h0000_0000, 32'h4060_0000}, 2);
    chk("restart_no_done", 32'(b0.done), 32'h0);
    wait_done(0, 2, 2, "restart");

    // async reset mid-RUN, between clock edges
    set_ops(0, {32'h3F80_0000, 32'h3F80_0000}, {32'h0, 32'h0});
    start_pulse(0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res0", res(0, 0), 32'h0);
    chk("arst_res1", res(0, 1), 32'h0);
    chk("arst_busy", 32'(b0.busy), 32'h0);
    chk("arst_done", 32'(b0.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet_done%0d", k), 32'(b0.done), 32'h0);
      chk($sformatf("arst_quiet_busy%0d", k), 32'(b0.busy), 32'h0);
    end

    // recovery after reset
    drive(0, {32'hC000_0000, 32'h3F80_0000}, {32'h3F00_0000, 32'h3F00_0000},
          {32'h0000_0000, 32'h3FC0_0000}, 2);
    wait_done(0, 2, 2, "recover");

    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bias_activation_seq.md
Name: bias_activation_seq

Overview:
- Downstream stage of the sequential matrix multiplier in an NN layer.
- Takes the L*1 float32 product vector (one float per output neuron), adds a per-neuron float32 bias and applies the layer activation.
- Processes LANES elements per clock, so the simulator/FPGA footprint scales with LANES rather than VLEN.
- Produces the layer output vector that feeds the next layer's multiplier.

Parameters:
- VLEN, 1, number of float32 elements (neurons) in the vector.
- LANES, 1, elements processed per clock; 1 <= LANES <= VLEN; VLEN need not be a multiple of LANES.
- ACT, 1, activation select: 0 = identity, 1 = ReLU, 2 = leaky ReLU.
- LEAKY_SHIFT, 3, leaky slope alpha = 2^-LEAKY_SHIFT; 1..8; used only when ACT = 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; captures in_vec and bias.
- in_vec  in  32*VLEN  multiplier result; element i at [32*i +: 32].
- bias  in  32*VLEN  bias vector, same layout.
- result  out  32*VLEN  activated output, same layout.
- busy  out  1  high while computing.
- done  out  1  high once result is complete; held until the next start.

Behaviour:
- Reset (asynchronous, rst_n low): result = 0, busy = 0, done = 0, state IDLE, group counter = 0, capture registers = 0.
- State machine:
  - IDLE --start--> RUN.
  - RUN --last group written--> DONE.
  - DONE --start--> RUN.
- Capture: on the edge where start = 1, in_vec and bias are copied into internal registers. Later input changes are ignored until the next start. busy goes 1, done goes 0, counter = 0.
- RUN: each edge processes elements [LANES*cnt, LANES*cnt + LANES - 1] from the captured operands and writes them to result.
  - Lanes with index >= VLEN in the final partial group are masked: no write.
  - cnt increments by 1 per edge.
- Completion: after G = ceil(VLEN/LANES) RUN edges, done = 1 and busy = 0 on the same edge that writes the last group.
  - Latency from the start edge to done high: exactly G cycles.
- start while RUN: restart. Recapture operands, cnt = 0, done stays 0. Partially written result elements may be stale until rewritten.
- start in DONE: same as from IDLE; result keeps its old values until each group is rewritten.
- Bias add: float32 addition per lane using the codebase float adder (combinational), with that adder's rounding behaviour.
- Activation, applied to sum s:
  - ACT 0: pass s unchanged.
  - ACT 1: sign = 1 and not NaN -> +0 (0x00000000). -0 -> +0. NaN passes through unchanged. Positive values and +inf pass through.
  - ACT 2: negative finite s -> exponent field decremented by LEAKY_SHIFT; mantissa and sign kept.
    - If exponent field <= LEAKY_SHIFT (including denormals), flush to -0 (0x80000000).
    - -inf stays -inf. NaN passes through.
    - Non-negative values pass through.
- result bits are stable outside the write edge of their group. done never pulses without a full pass.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs cleared. No completion is reported.

Decomposition:
- Shared package/include: float32 field constants (sign bit 31, exponent [30:23], mantissa [22:0], EXP_MAX 8'hFF), ACT encodings, the +0/-0 constants.
- One sub-module: bias_act_lane, one lane, combinational.
  - Instantiates the float adder.
  - Applies the ACT/LEAKY_SHIFT logic.
  - Instantiated LANES times.
- The top level owns the FSM, counter, capture registers and masked writeback.

Test Plan:
- VLEN=2, LANES=1, ACT=1; in_vec={0x3F800000 (1.0), 0xC0000000 (-2.0)}, bias both 0x3F000000 (0.5); pulse start.
  - Required: result = {0x3FC00000, 0x00000000}.
  - Required: done high exactly 2 cycles after the start edge; busy high in between.
- Same operands, ACT=2, LEAKY_SHIFT=2.
  - Required: element1 = 0xBEC00000 (-0.375).
  - Required: element with sum exponent field 0x01 flushes to 0x80000000.
- VLEN=5, LANES=2.
  - Required: done after 3 cycles.
  - Required: lane 1 of the last group writes nothing (no out-of-range index); all 5 elements correct.
- Restart: start pulse in the second RUN cycle with new operands.
  - Required: done rises G cycles after the second start, with the results of the new operands only.
- Async reset: drop rst_n mid-RUN between clock edges.
  - Required: result = 0, busy = 0 and done = 0 immediately; no done after rst_n releases until a new start.
- ACT=1 edge values: sums of NaN (0x7FC00000), -0, +inf.
  - Required: 0x7FC00000, 0x00000000, 0x7F800000 respectively.
  - Required: in_vec changes without a start do not alter the results.
